handshake_const_sink_27: RTL and testbench
==========================================

# handshake_const_sink_27

Receiving end of the constant-token channel: accepts data tokens on an elastic handshake input, strips the data, and re-emits a pure control token through a 2-entry elastic buffer. Every accepted data word is checked against the expected constant value (11'b01000011000 = 536, zero-extended). A sticky mismatch flag, the first offending word, and a running token count are kept for on-chip debug and scan-out. It sits downstream of constant generators in the dataflow fabric, where it closes data channels back into the control network.

## Interface
- DATA_WIDTH, 32, width of the incoming data channel
- EXPECTED, 11'b01000011000, expected constant; zero-extended to DATA_WIDTH for comparison
- COUNT_WIDTH, 16, width of the accepted-token counter
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-low (rst=0 resets on the next rising clk edge)
- ins  input  DATA_WIDTH  incoming data token
- ins_valid  input  1  incoming token valid
- ins_ready  output  1  block can accept a token this cycle
- outs_valid  output  1  control token available
- outs_ready  input  1  downstream accepts control token
- token_count  output  COUNT_WIDTH  number of accepted input tokens, modulo 2^COUNT_WIDTH
- mismatch  output  1  sticky: at least one accepted token differed from EXPECTED
- mismatch_data  output  DATA_WIDTH  data of the first mismatching token; 0 until one occurs

## Operation
- Input transfer: ins_valid && ins_ready at the rising edge. Output transfer: outs_valid && outs_ready.
- Occupancy counter occ ∈ {0,1,2}, encoded as states EMPTY, ONE, FULL.
  - EMPTY: ins_ready=1, outs_valid=0. Input transfer → ONE.
  - ONE: ins_ready=1, outs_valid=1. Input only → FULL; output only → EMPTY; both → ONE.
  - FULL: ins_ready=0, outs_valid=1. Output transfer → ONE. Input is ignored.
- ins_ready depends only on registered state (no combinational path from outs_ready). outs_valid depends only on registered state (no path from ins_valid).
- Compare: on each input transfer, if ins != {zeros, EXPECTED} then set mismatch. If mismatch was previously 0, also load mismatch_data <= ins. Later mismatches do not overwrite mismatch_data.
- token_count increments by 1 on every input transfer and wraps from 2^COUNT_WIDTH−1 to 0. No saturation.
- ins is ignored when ins_valid=0. Data contents never affect the handshake.
- Reset (rst=0 at the edge) forces occ=EMPTY, token_count=0, mismatch=0, mismatch_data=0. Reset wins over any simultaneous transfer. Tokens in flight are dropped.

## Timing
- Reset values: ins_ready=1, outs_valid=0, token_count=0, mismatch=0, mismatch_data=0.
- Latency: an input accepted at edge N gives outs_valid=1 in the cycle after edge N (1 cycle).
- Throughput: 1 token/cycle sustained while outs_ready=1. With outs_ready=0, two tokens are absorbed, then ins_ready=0.
- After a stall is released, ins_ready re-asserts in the cycle after the first output transfer.
- mismatch, mismatch_data and token_count update on the same edge as the input transfer that causes them.
- Output tokens cannot be withdrawn: once outs_valid=1 it stays 1 until an output transfer or reset.

## Structure
- Shared dataflow package holds:
  - the occupancy state enum (EMPTY/ONE/FULL)
  - the localparam for the constant-27 value 11'b01000011000, shared with the generator side
- One natural sub-module: handshake_ctrl_buffer_2 (a dataless 2-slot elastic buffer carrying occ and the handshake). Compare, capture and counter logic stay in the top.

## Test plan
- Reset behaviour: hold rst=0 for 3 cycles with ins_valid=1 → ins_ready=1, outs_valid=0, token_count=0, mismatch=0 throughout.
- Streaming: ins=536 with ins_valid=1 for 10 cycles, outs_ready=1 → 10 output tokens, each 1 cycle after its input; token_count=10; mismatch=0.
- Backpressure: outs_ready=0, ins_valid=1 continuously → exactly 2 inputs accepted, then ins_ready=0. Raise outs_ready → 2 tokens drain, then streaming resumes with no loss or duplication.
- Mismatch capture: accept 536, then 0x12345678, then 0xFFFFFFFF → mismatch=1 from the second transfer on; mismatch_data=0x12345678 and stays there; token_count=3.
- Counter wrap: with COUNT_WIDTH=4, accept 17 tokens → token_count=1.
- Mid-operation reset: FULL with mismatch=1, assert rst=0 for one cycle during a simultaneous output transfer → all outputs return to reset values on that edge, and no output token is seen afterwards.

Source files
------------

// File: rtl/handshake_const_sink_27_pkg.sv
// Shared dataflow definitions: occupancy encoding for 2-slot elastic buffers
// and the constant-27 token value used by both generator and sink sides.
package handshake_const_sink_27_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [10:0] CONST_27 = 11'b01000011000;

  // Number of tokens held for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e s);
    case (s)
      OCC_ONE:  return 2'd1;
      OCC_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/handshake_const_sink_27_ctrl_buffer.sv
// Dataless 2-slot elastic buffer: one-cycle latency, full throughput, and
// ready/valid taken from registered state only (no combinational cross paths).
module handshake_ctrl_buffer_2
  import handshake_const_sink_27_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       up_valid,
  output logic       up_ready,
  output logic       dn_valid,
  input  logic       dn_ready,
  output logic [1:0] level
);

  occ_e state;
  occ_e state_nxt;
  logic up_fire;
  logic dn_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    up_ready  = (state != OCC_FULL);
    dn_valid  = (state != OCC_EMPTY);
    up_fire   = up_valid && up_ready;
    dn_fire   = dn_valid && dn_ready;
    case (state)
      OCC_EMPTY: begin
        if (up_fire) state_nxt = OCC_ONE;
      end
      OCC_ONE: begin
        if (up_fire && !dn_fire)      state_nxt = OCC_FULL;
        else if (!up_fire && dn_fire) state_nxt = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (dn_fire) state_nxt = OCC_ONE;
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  assign level = occ_count(state);

endmodule

// File: rtl/handshake_const_sink_27.sv
// Constant-token sink: strips data into a 2-slot control buffer, flags the
// first word that differs from the expected constant and counts accepted tokens.
module handshake_const_sink_27
  import handshake_const_sink_27_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [10:0] EXPECTED    = CONST_27,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [COUNT_WIDTH-1:0] token_count,
  output logic                   mismatch,
  output logic [DATA_WIDTH-1:0]  mismatch_data
);

  localparam logic [DATA_WIDTH-1:0] EXPECTED_EXT = DATA_WIDTH'(EXPECTED);

  logic       in_fire;
  logic       word_bad;
  logic [1:0] buf_level;

  handshake_ctrl_buffer_2 u_buf (
    .clk      (clk),
    .rst      (rst),
    .up_valid (ins_valid),
    .up_ready (ins_ready),
    .dn_valid (outs_valid),
    .dn_ready (outs_ready),
    .level    (buf_level)
  );

  assign in_fire  = ins_valid && ins_ready;
  assign word_bad = (ins != EXPECTED_EXT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      token_count   <= '0;
      mismatch      <= 1'b0;
      mismatch_data <= '0;
    end else if (in_fire) begin
      token_count <= token_count + COUNT_WIDTH'(1);
      if (word_bad) begin
        mismatch <= 1'b1;
        // Only the first offending word is kept for debug scan-out.
        if (!mismatch) mismatch_data <= ins;
      end
    end
  end

  // The buffer never holds more than two tokens; a level of 3 means corrupted state.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (buf_level != 2'd3);
    end
  end

endmodule

// File: tb/tb_handshake_const_sink_27.sv
// Randomized and directed bench comparing two sink instances (16- and 4-bit counters)
// against an occupancy/count/first-mismatch reference model.
module tb_handshake_const_sink_27;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        outs_ready;

  logic        ins_ready, outs_valid, mismatch;
  logic [15:0] token_count;
  logic [31:0] mismatch_data;
  logic        ins_ready4, outs_valid4, mismatch4;
  logic [3:0]  token_count4;
  logic [31:0] mismatch_data4;

  int tests = 0;
  int fails = 0;

  // reference model state
  int          m_occ;
  int          m_cnt;
  int          m_cnt4;
  bit          m_mm;
  logic [31:0] m_md;

  always #5 clk = ~clk;

  handshake_const_sink_27 dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .token_count(token_count),
    .mismatch(mismatch), .mismatch_data(mismatch_data)
  );

  handshake_const_sink_27 #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .outs_valid(outs_valid4), .outs_ready(outs_ready), .token_count(token_count4),
    .mismatch(mismatch4), .mismatch_data(mismatch_data4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ins_ready",      64'(ins_ready),      64'(m_occ < 2));
    chk("outs_valid",     64'(outs_valid),     64'(m_occ > 0));
    chk("token_count",    64'(token_count),    64'(m_cnt));
    chk("mismatch",       64'(mismatch),       64'(m_mm));
    chk("mismatch_data",  64'(mismatch_data),  64'(m_md));
    chk("ins_ready4",     64'(ins_ready4),     64'(m_occ < 2));
    chk("outs_valid4",    64'(outs_valid4),    64'(m_occ > 0));
    chk("token_count4",   64'(token_count4),   64'(m_cnt4));
    chk("mismatch4",      64'(mismatch4),      64'(m_mm));
    chk("mismatch_data4", 64'(mismatch_data4), 64'(m_md));
  endtask

  // Drive one cycle, advance the model across the edge, then check at negedge.
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit o);
    bit in_f, out_f;
    rst = r; ins_valid = v; ins = d; outs_ready = o;
    @(posedge clk);
    if (!r) begin
      m_occ = 0; m_cnt = 0; m_cnt4 = 0; m_mm = 0; m_md = '0;
    end else begin
      in_f  = v && (m_occ < 2);
      out_f = o && (m_occ > 0);
      m_occ = m_occ + int'(in_f) - int'(out_f);
      if (in_f) begin
        m_cnt  = (m_cnt + 1) % 65536;
        m_cnt4 = (m_cnt4 + 1) % 16;
        if (d != 32'd536) begin
          if (!m_mm) m_md = d;
          m_mm = 1;
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    // reset held with valid asserted
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'd536, 1);
      chk("rst_ins_ready", 64'(ins_ready), 64'd1);
      chk("rst_outs_valid", 64'(outs_valid), 64'd0);
      chk("rst_count", 64'(token_count), 64'd0);
      chk("rst_mismatch", 64'(mismatch), 64'd0);
    end

    // streaming: latency one cycle, 1 token/cycle
    step(1, 1, 32'd536, 1);
    chk("lat_outs_valid", 64'(outs_valid), 64'd1);
    for (int i = 1; i < 10; i++) step(1, 1, 32'd536, 1);
    chk("stream_count", 64'(token_count), 64'd10);
    chk("stream_mismatch", 64'(mismatch), 64'd0);
    step(1, 0, 32'd0, 1);
    chk("drained", 64'(outs_valid), 64'd0);

    // backpressure from empty: exactly two absorbed
    for (int i = 0; i < 5; i++) step(1, 1, 32'd536, 0);
    chk("bp_count", 64'(token_count), 64'd12);
    chk("bp_ready", 64'(ins_ready), 64'd0);
    step(1, 1, 32'd536, 1);
    chk("release_ready", 64'(ins_ready), 64'd1);
    for (int i = 0; i < 5; i++) step(1, 1, 32'd536, 1);
    chk("resume_count", 64'(token_count), 64'd17);
    chk("resume_count4", 64'(token_count4), 64'd1);

    // mismatch capture keeps the first offender
    step(0, 0, 32'd0, 1);
    step(1, 1, 32'd536, 1);
    chk("mm_first_ok", 64'(mismatch), 64'd0);
    step(1, 1, 32'h12345678, 1);
    chk("mm_set", 64'(mismatch), 64'd1);
    chk("mm_data", 64'(mismatch_data), 64'h12345678);
    step(1, 1, 32'hFFFFFFFF, 1);
    chk("mm_data_kept", 64'(mismatch_data), 64'h12345678);
    chk("mm_count", 64'(token_count), 64'd3);

    // counter wrap on the 4-bit instance
    step(0, 0, 32'd0, 1);
    for (int i = 0; i < 17; i++) step(1, 1, 32'd536, 1);
    chk("wrap_count4", 64'(token_count4), 64'd1);
    chk("wrap_count16", 64'(token_count), 64'd17);

    // reset while FULL with a simultaneous output transfer
    step(0, 0, 32'd0, 1);
    step(1, 1, 32'h00000BAD, 0);
    step(1, 1, 32'd536, 0);
    chk("full_valid", 64'(outs_valid), 64'd1);
    chk("full_ready", 64'(ins_ready), 64'd0);
    chk("full_mm", 64'(mismatch), 64'd1);
    step(0, 1, 32'd536, 1);
    chk("mid_rst_valid", 64'(outs_valid), 64'd0);
    chk("mid_rst_ready", 64'(ins_ready), 64'd1);
    chk("mid_rst_count", 64'(token_count), 64'd0);
    chk("mid_rst_mm", 64'(mismatch), 64'd0);
    chk("mid_rst_md", 64'(mismatch_data), 64'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'd0, 1);
    chk("no_ghost_token", 64'(outs_valid), 64'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) != 0,
           $urandom_range(0, 2) != 0,
           ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'd536,
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
